// File: rtl/adc_frame_packer.sv
// ADC capture and frame packer: tags each strobe-clocked sample with a free-running tick count,
// packs SAMPLES_PER_FRAME tagged samples MSB-first into a frame, and buffers frames for GPIF2.

// Show-ahead frame FIFO with an occupancy counter and a drop pulse for pushes refused while full.
// Head visible on the edge after push into an empty FIFO; a full FIFO accepts a push only alongside a pop.
module adc_frame_fifo #(
   parameter  int W     = 32,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_vld,
   input  logic [W-1:0]  push_dat,
   input  logic          pop_rdy,
   output logic          head_vld,
   output logic [W-1:0]  head_dat,
   output logic [LW-1:0] level,
   output logic          drop
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          full;
   logic          push;
   logic          pop;

   assign head_vld = (level != '0);
   assign full     = (level == LW'(DEPTH));
   assign pop      = head_vld & pop_rdy;
   // A pop on the same edge frees the slot, so a full FIFO still takes the push.
   assign push     = push_vld & (~full | pop);
   assign drop     = push_vld & full & ~pop;

   // RAM contents are not reset; gating keeps the output at zero while empty.
   assign head_dat = head_vld ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_dat;
      end
   end

endmodule

// Top-level packer: one sample per strobe edge, frame pushed on the edge that captures its last slot.
// Frame visible one edge after that push; when the FIFO is full new frames are dropped and counted.
module adc_frame_packer #(
   parameter  int SAMPLE_W          = 10,
   parameter  int TAG_W             = 6,
   parameter  int SAMPLES_PER_FRAME = 2,
   parameter  int FIFO_DEPTH        = 16,
   localparam int FIELD_W           = SAMPLE_W + TAG_W,
   localparam int FRAME_W           = SAMPLES_PER_FRAME * FIELD_W,
   localparam int LW                = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                ADC_STROBE_IN,
   input  logic                ARESET_IN,
   input  logic [SAMPLE_W-1:0] ADC_BUS_IN,
   input  logic                ENABLE_IN,
   input  logic                FRAME_READY_IN,
   input  logic                CLEAR_OVF_IN,
   output logic [FRAME_W-1:0]  FRAME_DATA_OUT,
   output logic                FRAME_VALID_OUT,
   output logic [LW-1:0]       FIFO_LEVEL_OUT,
   output logic                OVERFLOW_OUT,
   output logic [15:0]         DROP_COUNT_OUT
);

   localparam int            SW        = (SAMPLES_PER_FRAME > 1) ? $clog2(SAMPLES_PER_FRAME) : 1;
   localparam logic [SW-1:0] LAST_SLOT = SW'(SAMPLES_PER_FRAME - 1);

   logic [TAG_W-1:0]   tag;
   logic [SW-1:0]      slot;
   logic [FRAME_W-1:0] frame_q;
   logic [FRAME_W-1:0] frame_d;
   logic [FIELD_W-1:0] field;
   logic               last_slot;
   logic               frame_push;
   logic               fifo_drop;

   assign field      = {tag, ADC_BUS_IN};
   assign last_slot  = (slot == LAST_SLOT);
   assign frame_push = ENABLE_IN & last_slot;

   // Slot 0 lands in the MSBs; the pushed frame already includes this edge's sample.
   always_comb begin
      frame_d = frame_q;
      frame_d[(SAMPLES_PER_FRAME - 1 - int'(slot)) * FIELD_W +: FIELD_W] = field;
   end

   always_ff @(posedge ADC_STROBE_IN or posedge ARESET_IN) begin
      if (ARESET_IN) begin
         tag     <= '0;
         slot    <= '0;
         frame_q <= '0;
      end else begin
         tag <= tag + TAG_W'(1);
         if (!ENABLE_IN) begin
            slot <= '0;
         end else begin
            frame_q <= frame_d;
            slot    <= last_slot ? '0 : slot + SW'(1);
         end
      end
   end

   adc_frame_fifo #(
      .W     (FRAME_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (ADC_STROBE_IN),
      .rst      (ARESET_IN),
      .push_vld (frame_push),
      .push_dat (frame_d),
      .pop_rdy  (FRAME_READY_IN),
      .head_vld (FRAME_VALID_OUT),
      .head_dat (FRAME_DATA_OUT),
      .level    (FIFO_LEVEL_OUT),
      .drop     (fifo_drop)
   );

   // A drop on the same edge as a clear restarts the count at one rather than zero.
   always_ff @(posedge ADC_STROBE_IN or posedge ARESET_IN) begin
      if (ARESET_IN) begin
         OVERFLOW_OUT   <= 1'b0;
         DROP_COUNT_OUT <= '0;
      end else if (fifo_drop) begin
         OVERFLOW_OUT <= 1'b1;
         if (CLEAR_OVF_IN) begin
            DROP_COUNT_OUT <= 16'd1;
         end else if (DROP_COUNT_OUT != 16'hFFFF) begin
            DROP_COUNT_OUT <= DROP_COUNT_OUT + 16'd1;
         end
      end else if (CLEAR_OVF_IN) begin
         OVERFLOW_OUT   <= 1'b0;
         DROP_COUNT_OUT <= '0;
      end
   end

endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed bench for adc_frame_packer at default parameters (10-bit samples, 6-bit tags, 2 samples per frame).
module tb_adc_frame_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  adc = '0;
   logic        en  = 1'b0;
   logic        rdy = 1'b0;
   logic        clr = 1'b0;
   logic [31:0] dat;
   logic        vld;
   logic [4:0]  lvl;
   logic        ovf;
   logic [15:0] cnt;

   int total = 0;
   int bad   = 0;
   int tick  = 0;

   always #5 clk = ~clk;

   adc_frame_packer dut (
      .ADC_STROBE_IN   (clk),
      .ARESET_IN       (rst),
      .ADC_BUS_IN      (adc),
      .ENABLE_IN       (en),
      .FRAME_READY_IN  (rdy),
      .CLEAR_OVF_IN    (clr),
      .FRAME_DATA_OUT  (dat),
      .FRAME_VALID_OUT (vld),
      .FIFO_LEVEL_OUT  (lvl),
      .OVERFLOW_OUT    (ovf),
      .DROP_COUNT_OUT  (cnt)
   );

   typedef struct {
      logic        en;
      logic        rdy;
      logic [9:0]  adc;
      logic        vld;
      logic [31:0] dat;
      logic [4:0]  lvl;
   } vec_t;

   vec_t        tv [14];
   logic [31:0] fr [18];
   logic [31:0] f;
   logic [31:0] f31;
   logic [31:0] f32;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input logic e, input logic r, input logic c, input logic [9:0] a);
      en  = e;
      rdy = r;
      clr = c;
      adc = a;
      @(posedge clk);
      #1;
      tick++;
   endtask

   task automatic cap2(input logic r0, input logic r1, input logic c1, output logic [31:0] fo);
      logic [9:0] d0, d1;
      logic [5:0] t0, t1;
      t0 = 6'(tick);
      d0 = 10'(tick * 7 + 3);
      step(1'b1, r0, 1'b0, d0);
      t1 = 6'(tick);
      d1 = 10'(tick * 7 + 3);
      step(1'b1, r1, c1, d1);
      fo = {t0, d0, t1, d1};
   endtask

   task automatic check_zero(input string ph);
      chk({ph, "_vld"}, 64'(vld), 64'd0);
      chk({ph, "_dat"}, 64'(dat), 64'd0);
      chk({ph, "_lvl"}, 64'(lvl), 64'd0);
      chk({ph, "_ovf"}, 64'(ovf), 64'd0);
      chk({ph, "_cnt"}, 64'(cnt), 64'd0);
   endtask

   task automatic do_reset(input string ph);
      en  = 1'b0;
      rdy = 1'b0;
      clr = 1'b0;
      rst = 1'b1;
      #2;
      check_zero(ph);
      @(posedge clk);
      #1;
      rst  = 1'b0;
      tick = 0;
   endtask

   initial begin
      //            en    rdy   adc      vld   dat           lvl
      tv[0]  = '{1'b1, 1'b1, 10'h155, 1'b0, 32'h0,        5'd0};
      tv[1]  = '{1'b1, 1'b1, 10'h2AA, 1'b1, 32'h015506AA, 5'd1};
      tv[2]  = '{1'b0, 1'b1, 10'h000, 1'b0, 32'h0,        5'd0};
      tv[3]  = '{1'b1, 1'b0, 10'h3FF, 1'b0, 32'h0,        5'd0};
      tv[4]  = '{1'b1, 1'b0, 10'h001, 1'b1, 32'h0FFF1001, 5'd1};
      tv[5]  = '{1'b0, 1'b0, 10'h000, 1'b1, 32'h0FFF1001, 5'd1};
      tv[6]  = '{1'b0, 1'b1, 10'h000, 1'b0, 32'h0,        5'd0};
      tv[7]  = '{1'b1, 1'b0, 10'h0AB, 1'b0, 32'h0,        5'd0};
      tv[8]  = '{1'b0, 1'b0, 10'h000, 1'b0, 32'h0,        5'd0};
      tv[9]  = '{1'b0, 1'b0, 10'h000, 1'b0, 32'h0,        5'd0};
      tv[10] = '{1'b0, 1'b0, 10'h000, 1'b0, 32'h0,        5'd0};
      tv[11] = '{1'b1, 1'b0, 10'h0CD, 1'b0, 32'h0,        5'd0};
      tv[12] = '{1'b1, 1'b0, 10'h0EF, 1'b1, 32'h2CCD30EF, 5'd1};
      tv[13] = '{1'b0, 1'b1, 10'h000, 1'b0, 32'h0,        5'd0};

      // Reset state, then first frames, disabled drain and a 3-clock enable gap.
      do_reset("rst0");
      for (int i = 0; i < 14; i++) begin
         step(tv[i].en, tv[i].rdy, 1'b0, tv[i].adc);
         chk($sformatf("tv%0d_vld", i), 64'(vld), 64'(tv[i].vld));
         chk($sformatf("tv%0d_lvl", i), 64'(lvl), 64'(tv[i].lvl));
         chk($sformatf("tv%0d_ovf", i), 64'(ovf), 64'd0);
         if (tv[i].vld) begin
            chk($sformatf("tv%0d_dat", i), 64'(dat), 64'(tv[i].dat));
         end
      end

      // Continuous capture across the tag wrap at full throughput.
      do_reset("rst1");
      f31 = '0;
      f32 = '0;
      for (int i = 0; i < 130; i++) begin
         step(1'b1, 1'b1, 1'b0, 10'(i));
         if (i % 2 == 1) begin
            f = {6'(i - 1), 10'(i - 1), 6'(i), 10'(i)};
            chk($sformatf("wrap%0d_vld", i), 64'(vld), 64'd1);
            chk($sformatf("wrap%0d_dat", i), 64'(dat), 64'(f));
            if (i == 63) f31 = dat;
            if (i == 65) f32 = dat;
         end else begin
            chk($sformatf("wrap%0d_vld", i), 64'(vld), 64'd0);
         end
      end
      chk("wrap_frame31", 64'(f31), 64'h00000000F83EFC3F);
      chk("wrap_frame32", 64'(f32), 64'h0000000000400441);

      // Backpressure: 17 frames into a 16-deep FIFO, then drain in order.
      do_reset("rst2");
      for (int j = 0; j < 17; j++) begin
         cap2(1'b0, 1'b0, 1'b0, fr[j]);
         chk($sformatf("bp%0d_lvl", j), 64'(lvl), 64'((j < 16) ? j + 1 : 16));
         chk($sformatf("bp%0d_ovf", j), 64'(ovf), 64'((j == 16) ? 1 : 0));
         chk($sformatf("bp%0d_cnt", j), 64'(cnt), 64'((j == 16) ? 1 : 0));
      end
      for (int j = 0; j < 16; j++) begin
         chk($sformatf("drain%0d_vld", j), 64'(vld), 64'd1);
         chk($sformatf("drain%0d_dat", j), 64'(dat), 64'(fr[j]));
         step(1'b0, 1'b1, 1'b0, 10'h0);
      end
      chk("drain_end_vld", 64'(vld), 64'd0);
      chk("drain_end_lvl", 64'(lvl), 64'd0);
      chk("drain_end_ovf", 64'(ovf), 64'd1);
      chk("drain_end_cnt", 64'(cnt), 64'd1);

      // Clear, refill, push+pop at full, then a drop coincident with clear.
      step(1'b0, 1'b0, 1'b1, 10'h0);
      chk("clr_ovf", 64'(ovf), 64'd0);
      chk("clr_cnt", 64'(cnt), 64'd0);
      for (int j = 0; j < 16; j++) begin
         cap2(1'b0, 1'b0, 1'b0, fr[j]);
      end
      chk("full_lvl", 64'(lvl), 64'd16);
      cap2(1'b0, 1'b1, 1'b0, fr[16]);
      chk("pp_lvl", 64'(lvl), 64'd16);
      chk("pp_ovf", 64'(ovf), 64'd0);
      chk("pp_cnt", 64'(cnt), 64'd0);
      chk("pp_head", 64'(dat), 64'(fr[1]));
      cap2(1'b0, 1'b0, 1'b1, fr[17]);
      chk("clrdrop_ovf", 64'(ovf), 64'd1);
      chk("clrdrop_cnt", 64'(cnt), 64'd1);
      chk("clrdrop_lvl", 64'(lvl), 64'd16);
      cap2(1'b0, 1'b0, 1'b0, f);
      chk("drop2_cnt", 64'(cnt), 64'd2);
      chk("drop2_head", 64'(dat), 64'(fr[1]));

      // Drain to level 5, start a frame, and reset asynchronously mid-frame.
      for (int k = 0; k < 11; k++) begin
         step(1'b0, 1'b1, 1'b0, 10'h0);
      end
      chk("pre_rst_lvl", 64'(lvl), 64'd5);
      chk("pre_rst_head", 64'(dat), 64'(fr[12]));
      step(1'b1, 1'b0, 1'b0, 10'h3C3);
      do_reset("midrst");
      step(1'b1, 1'b1, 1'b0, 10'h155);
      chk("post_rst_vld0", 64'(vld), 64'd0);
      step(1'b1, 1'b1, 1'b0, 10'h2AA);
      chk("post_rst_vld1", 64'(vld), 64'd1);
      chk("post_rst_dat", 64'(dat), 64'h00000000015506AA);
      chk("post_rst_lvl", 64'(lvl), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
